contador_bcd_mux: RTL and testbench
===================================

// Module: contador_bcd_mux
// PURPOSE
//  Two-digit BCD up/down counter with a tick prescaler and a time-multiplexed digit output.
//  Sits directly upstream of the seven-segment converter.
//  Each cycle it presents one BCD nibble on bcd_out and the matching one-hot digit select on sel.
//  The converter turns that nibble into segment lines a..g.
// PARAMETERS
//  PRESCALE  4  clk cycles per count step while en=1 (>=1; 1 = step every cycle)
//  MUX_DIV   2  clk cycles each digit is held on bcd_out before switching (>=1)
// PORTS
//  clk       in   1  system clock, rising-edge
//  rst       in   1  asynchronous, active-high reset
//  en        in   1  count enable; gates prescaler advance
//  up        in   1  1 = count up, 0 = count down; sampled on the step cycle
//  load      in   1  synchronous load strobe
//  load_val  in   8  {tens,units} BCD value to load
//  count     out  8  {tens,units} registered BCD count
//  bcd_out   out  4  nibble of the digit currently selected (units when sel=01, tens when sel=10)
//  sel       out  2  one-hot digit select: 01 = units, 10 = tens
//  carry     out  1  one-cycle pulse on wrap 99->00 (up) or 00->99 (down)
// BEHAVIOUR
//  Reset (rst=1, async): count=8'h00, prescaler=0, mux counter=0, sel=2'b01, carry=0.
//   bcd_out=4'h0 follows from count and sel. Reset mid-operation aborts the count and the mux phase immediately.
//  Prescaler: increments every cycle en=1; holds when en=0 (no clear).
//   When prescaler==PRESCALE-1 and en=1: step fires, prescaler returns to 0.
//   With en=1 the first step occurs on the PRESCALE-th rising edge after reset release.
//  Step, up=1:
//   units 0-8 -> +1.
//   units 9 -> units 0, tens +1.
//   99 -> 00 with carry=1 for that cycle.
//  Step, up=0:
//   units 1-9 -> -1.
//   units 0 -> units 9, tens -1.
//   00 -> 99 with carry=1 for that cycle.
//  carry is registered: high exactly one cycle, the cycle count shows the wrapped value.
//  Load, priority over step:
//   load=1 -> count<=load_val next edge, prescaler<=0, carry<=0, even if a step fires that cycle.
//   Any nibble >9 in load_val is clamped to 9 per digit (8'hA3 -> 8'h93, 8'hFF -> 8'h99).
//   Load works with en=0.
//  count never holds a non-BCD nibble.
//  Mux:
//   Free-running counter, independent of en and load.
//   Every MUX_DIV cycles sel toggles 01<->10.
//   bcd_out is combinational from sel and registered count: no added latency.
//   A count change is visible on bcd_out the same cycle if its digit is selected.
//   sel is never 00 or 11.
//  up changing between steps has no effect until the next step.
// TESTING
//  1 Reset: assert rst mid-count at count=8'h47 -> count=00, sel=01, carry=0, bcd_out=0 without waiting for clk.
//  2 Up count: PRESCALE=4, en=1, up=1 from 00 -> count=01 at edge 4, 02 at edge 8; count=10 after 10 steps.
//  3 Up wrap: load 8'h98, up=1 -> steps give 99 then 00 with carry=1 for exactly one cycle.
//  4 Down wrap: load 8'h01, up=0 -> steps give 00 then 99 with carry pulse; 8'h10 steps to 8'h09.
//  5 Load vs step: load=1 with load_val=8'hA3 on a step cycle -> count=93, no carry.
//    The next step follows PRESCALE cycles later.
//  6 Mux: MUX_DIV=2, count=8'h57 -> sel/bcd_out alternate 01/7 and 10/5 every 2 cycles.
//    The alternation continues with en=0.

Source files
------------

// File: rtl/contador_bcd_mux.sv
// Two-digit BCD up/down counter with a step prescaler, a synchronous clamped
// load, and a time-multiplexed digit output for a seven-segment converter.
module contador_bcd_mux #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned MUX_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic [3:0] bcd_out,
    output logic [1:0] sel,
    output logic       carry
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [MW-1:0] MUX_LAST   = MW'(MUX_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [MW-1:0] r_mux;
    logic [3:0]    r_units;
    logic [3:0]    r_tens;
    logic [1:0]    r_sel;
    logic          r_carry;

    logic          w_step;
    logic [3:0]    w_units_nxt;
    logic [3:0]    w_tens_nxt;
    logic          w_wrap;
    logic [3:0]    w_load_units;
    logic [3:0]    w_load_tens;

    // Saturate a loaded nibble to 9 so count always stays valid BCD.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign w_step       = en && (r_presc == PRESC_LAST);
    assign w_load_units = clamp_digit(load_val[3:0]);
    assign w_load_tens  = clamp_digit(load_val[7:4]);

    // Next BCD value for one step in the requested direction, with wrap flag.
    always_comb begin
        w_units_nxt = r_units;
        w_tens_nxt  = r_tens;
        w_wrap      = 1'b0;
        if (up) begin
            if (r_units == 4'd9) begin
                w_units_nxt = 4'd0;
                if (r_tens == 4'd9) begin
                    w_tens_nxt = 4'd0;
                    w_wrap     = 1'b1;
                end else begin
                    w_tens_nxt = r_tens + 4'd1;
                end
            end else begin
                w_units_nxt = r_units + 4'd1;
            end
        end else begin
            if (r_units == 4'd0) begin
                w_units_nxt = 4'd9;
                if (r_tens == 4'd0) begin
                    w_tens_nxt = 4'd9;
                    w_wrap     = 1'b1;
                end else begin
                    w_tens_nxt = r_tens - 4'd1;
                end
            end else begin
                w_units_nxt = r_units - 4'd1;
            end
        end
    end

    // Prescaler: advances only while enabled, restarts on step or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
        end else if (en) begin
            if (w_step) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Count and carry: load wins over a coincident step; carry marks a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_carry <= 1'b0;
        end else if (load) begin
            r_units <= w_load_units;
            r_tens  <= w_load_tens;
            r_carry <= 1'b0;
        end else if (w_step) begin
            r_units <= w_units_nxt;
            r_tens  <= w_tens_nxt;
            r_carry <= w_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    // Free-running digit mux: swap the one-hot select every MUX_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mux <= '0;
            r_sel <= 2'b01;
        end else if (r_mux == MUX_LAST) begin
            r_mux <= '0;
            r_sel <= {r_sel[0], r_sel[1]};
        end else begin
            r_mux <= r_mux + MW'(1);
        end
    end

    assign count   = {r_tens, r_units};
    assign sel     = r_sel;
    assign carry   = r_carry;
    assign bcd_out = r_sel[1] ? r_tens : r_units;

endmodule

// File: tb/tb_contador_bcd_mux.sv
// Scoreboard bench for contador_bcd_mux: a decimal reference model pushes the
// expected outputs after every clock edge and a negedge monitor compares them.
module tb_contador_bcd_mux;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned MUX_DIV  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic [3:0] bcd_out;
    logic [1:0] sel;
    logic       carry;

    typedef struct {
        logic [7:0] count;
        logic [1:0] sel;
        logic [3:0] bcd;
        logic       carry;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    contador_bcd_mux #(
        .PRESCALE(PRESCALE),
        .MUX_DIV (MUX_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .bcd_out (bcd_out),
        .sel     (sel),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int dclamp(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    // Reference model: count kept as a decimal 0..99, mux phase from cycle count.
    initial begin
        int   v;
        int   presc;
        int   mcyc;
        bit   mcarry;
        bit   tens_phase;
        exp_t e;
        v = 0; presc = 0; mcyc = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                v = 0; presc = 0; mcyc = 0;
                q.delete();
            end else begin
                mcarry = 1'b0;
                if (load) begin
                    v = dclamp(int'(load_val[7:4])) * 10 + dclamp(int'(load_val[3:0]));
                    presc = 0;
                end else if (en) begin
                    if (presc == int'(PRESCALE) - 1) begin
                        presc = 0;
                        if (up) begin
                            mcarry = (v == 99);
                            v = (v + 1) % 100;
                        end else begin
                            mcarry = (v == 0);
                            v = (v + 99) % 100;
                        end
                    end else begin
                        presc++;
                    end
                end
                mcyc++;
                tens_phase = ((mcyc / int'(MUX_DIV)) % 2) == 1;
                e.count = {4'(v / 10), 4'(v % 10)};
                e.sel   = tens_phase ? 2'b10 : 2'b01;
                e.bcd   = tens_phase ? 4'(v / 10) : 4'(v % 10);
                e.carry = mcarry;
                q.push_back(e);
            end
        end
    end

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (!rst && q.size() > 0) begin
                m = q.pop_front();
                chk("count",   count,          m.count);
                chk("sel",     {6'd0, sel},    {6'd0, m.sel});
                chk("bcd_out", {4'd0, bcd_out}, {4'd0, m.bcd});
                chk("carry",   {7'd0, carry},  {7'd0, m.carry});
            end
        end
    end

    task automatic drive(input logic e, input logic u, input logic l,
                         input logic [7:0] lv, input int n);
        en = e; up = u; load = l; load_val = lv;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_count"}, count, 8'h00);
        chk({tag, "_sel"}, {6'd0, sel}, 8'h01);
        chk({tag, "_carry"}, {7'd0, carry}, 8'h00);
        chk({tag, "_bcd"}, {4'd0, bcd_out}, 8'h00);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_check("rst_init");
        rst = 1'b0;

        // Up count from 00 through 10 steps and beyond.
        drive(1, 1, 0, 8'h00, 45);
        // Up wrap from 98.
        drive(0, 1, 1, 8'h98, 1);
        drive(1, 1, 0, 8'h00, 12);
        // Down wrap from 01, then tens borrow from 10.
        drive(0, 0, 1, 8'h01, 1);
        drive(1, 0, 0, 8'h00, 12);
        drive(0, 0, 1, 8'h10, 1);
        drive(1, 0, 0, 8'h00, 5);
        // Load coinciding with a step cycle, clamped value, then normal steps.
        drive(0, 1, 1, 8'h20, 1);
        drive(1, 1, 0, 8'h00, 3);
        drive(1, 1, 1, 8'hA3, 1);
        drive(1, 1, 0, 8'h00, 9);
        drive(1, 0, 1, 8'hFF, 1);
        // Mux alternation with counting disabled.
        drive(0, 1, 1, 8'h57, 1);
        drive(0, 1, 0, 8'h00, 10);
        // Asynchronous reset in the middle of counting at 47.
        drive(1, 1, 1, 8'h47, 1);
        drive(1, 1, 0, 8'h00, 2);
        chk("pre_rst_count", count, 8'h47);
        rst = 1'b1;
        #1;
        rst_check("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(logic'($urandom_range(3) != 0), logic'($urandom_range(1)),
                  logic'($urandom_range(15) == 0), 8'($urandom_range(255)), 1);
        end

        drive(0, 0, 0, 8'h00, 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
